// File: rtl/rot_pkg.sv
// Shared definitions for the rotated-sync aligner: FSM encodings and
// 8-bit rotate helpers used by the design and the bench model.
package rot_pkg;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] VERIFY = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [7:0] r;
        r = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n) r = {r[6:0], r[7]};
        end
        return r;
    endfunction

    function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] n);
        logic [7:0] r;
        r = x;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < n) r = {r[0], r[7:1]};
        end
        return r;
    endfunction

    // True when every rotation of s is unique, so the HUNT search is unambiguous.
    function automatic logic sync_rots_distinct(input logic [7:0] s);
        logic ok;
        ok = 1'b1;
        for (int unsigned a = 0; a < 8; a++) begin
            for (int unsigned b = a + 1; b < 8; b++) begin
                if (rotl8(s, 3'(a)) == rotl8(s, 3'(b))) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/rot_right8.sv
// Combinational 8-bit rotate-right by a 3-bit amount; amount 0 passes data through.
module rot_right8 (
    input  logic [7:0] data,
    input  logic [2:0] amt,
    output logic [7:0] result
);

    logic [15:0] dbl;

    always_comb begin
        dbl    = {data, data} >> amt;
        result = dbl[7:0];
    end

endmodule

// File: rtl/rot_aligner.sv
// Hunts for a rotated sync byte, qualifies lock over several frames and
// de-rotates the payload stream by the captured rotation amount.
module rot_aligner
    import rot_pkg::*;
#(
    parameter logic [7:0]  SYNC      = 8'hA5,
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned LOCK_CNT  = 2,
    parameter int unsigned MISS_CNT  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_sof,
    output logic       locked,
    output logic [2:0] rot_amt
);

    if (!sync_rots_distinct(SYNC)) begin : g_bad_sync
        $error("rot_aligner: rotations of SYNC are not all distinct");
    end
    if (FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_frame
        $error("rot_aligner: FRAME_LEN out of range");
    end
    if (LOCK_CNT < 1 || LOCK_CNT > 15 || MISS_CNT < 1 || MISS_CNT > 15) begin : g_bad_cnt
        $error("rot_aligner: LOCK_CNT/MISS_CNT out of range");
    end

    localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);
    localparam logic [3:0] LOCK_LIM  = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_LIM  = 4'(MISS_CNT);

    logic [1:0] state;
    logic [7:0] beat_cnt;
    logic [3:0] good_cnt;
    logic [3:0] miss_cnt;
    logic [2:0] k;

    logic [7:0] hit;
    logic       any_hit;
    logic [2:0] hit_j;
    logic       match_k;
    logic [7:0] beat_nxt;
    logic       sync_slot;
    logic [7:0] derot;

    always_comb begin
        hit     = '0;
        any_hit = 1'b0;
        hit_j   = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            hit[j] = (in_data == rotl8(SYNC, 3'(j)));
        end
        // Lowest matching rotation wins.
        for (int unsigned j = 0; j < 8; j++) begin
            if (hit[j] && !any_hit) begin
                any_hit = 1'b1;
                hit_j   = 3'(j);
            end
        end
        match_k   = hit[k];
        sync_slot = (beat_cnt == '0);
        beat_nxt  = (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 8'd1;
    end

    rot_right8 u_derot (
        .data   (in_data),
        .amt    (k),
        .result (derot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            beat_cnt  <= '0;
            good_cnt  <= '0;
            miss_cnt  <= '0;
            k         <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        if (any_hit) begin
                            k        <= hit_j;
                            beat_cnt <= 8'd1;
                            good_cnt <= 4'd1;
                            miss_cnt <= '0;
                            state    <= (LOCK_LIM == 4'd1) ? LOCKED : VERIFY;
                        end
                    end
                    VERIFY: begin
                        beat_cnt <= beat_nxt;
                        if (sync_slot) begin
                            if (match_k) begin
                                good_cnt <= good_cnt + 4'd1;
                                if (good_cnt + 4'd1 == LOCK_LIM) begin
                                    state    <= LOCKED;
                                    miss_cnt <= '0;
                                end
                            end else begin
                                state    <= HUNT;
                                beat_cnt <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        beat_cnt <= beat_nxt;
                        if (sync_slot) begin
                            if (match_k) begin
                                miss_cnt <= '0;
                            end else if (miss_cnt + 4'd1 == MISS_LIM) begin
                                state    <= HUNT;
                                beat_cnt <= '0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 4'd1;
                            end
                        end else begin
                            out_data  <= derot;
                            out_valid <= 1'b1;
                            out_sof   <= (beat_cnt == 8'd1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign locked  = (state == LOCKED);
    assign rot_amt = k;

endmodule

// File: tb/tb_rot_aligner.sv
// Directed bench for rot_aligner with SYNC=A5, FRAME_LEN=4, LOCK_CNT=2, MISS_CNT=2.
module tb_rot_aligner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_sof;
    logic       locked;
    logic [2:0] rot_amt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    rot_aligner #(
        .SYNC      (8'hA5),
        .FRAME_LEN (4),
        .LOCK_CNT  (2),
        .MISS_CNT  (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_sof   (out_sof),
        .locked    (locked),
        .rot_amt   (rot_amt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // One cycle: drive inputs, clock, then check the registered response.
    task automatic step(input string tag, input logic [7:0] d, input logic v,
                        input logic eov, input logic [7:0] eod, input logic esof,
                        input logic elk);
        in_data  = d;
        in_valid = v;
        @(posedge clk);
        #1;
        check({tag, ".ov"}, 32'(out_valid), 32'(eov));
        check({tag, ".sof"}, 32'(out_sof), 32'(esof));
        check({tag, ".lk"}, 32'(locked), 32'(elk));
        if (eov) check({tag, ".od"}, 32'(out_data), 32'(eod));
    endtask

    task automatic frm(input string tag, input logic [7:0] s, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] c, input logic lks,
                       input logic eo, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] ec);
        step({tag, ".s"}, s, 1'b1, 1'b0, 8'h00, 1'b0, lks);
        step({tag, ".p0"}, a, 1'b1, eo, ea, eo, lks);
        step({tag, ".p1"}, b, 1'b1, eo, eb, 1'b0, lks);
        step({tag, ".p2"}, c, 1'b1, eo, ec, 1'b0, lks);
    endtask

    task automatic idle(input string tag, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(tag, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        rst_n    = 1'b0;
        #2;
        check({tag, ".ov"}, 32'(out_valid), 32'd0);
        check({tag, ".lk"}, 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset held with random traffic
        for (int i = 0; i < 4; i++) begin
            in_data  = 8'($urandom);
            in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst.od", 32'(out_data), 32'd0);
            check("rst.ov", 32'(out_valid), 32'd0);
            check("rst.sof", 32'(out_sof), 32'd0);
            check("rst.lk", 32'(locked), 32'd0);
            check("rst.k", 32'(rot_amt), 32'd0);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        check("rel.lk", 32'(locked), 32'd0);

        // 2: lock with k=3
        frm("k3f1", 8'h2D, 8'h0C, 8'h0C, 8'h0C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        check("k3.amt", 32'(rot_amt), 32'd3);
        frm("k3f2", 8'h2D, 8'h0C, 8'h0C, 8'h0C, 1'b1, 1'b1, 8'h81, 8'h81, 8'h81);
        check("k3.amt2", 32'(rot_amt), 32'd3);

        // 3: k=0 passthrough
        do_reset("r3");
        frm("k0f1", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        frm("k0f2", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
        check("k0.amt", 32'(rot_amt), 32'd0);

        // 4: idle gaps inside locked frames
        for (int f = 0; f < 3; f++) begin
            step("gap.s", 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
            idle("gap.i0", $urandom_range(0, 2));
            step("gap.p0", 8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1);
            idle("gap.i1", $urandom_range(0, 2));
            step("gap.p1", 8'h34, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1);
            idle("gap.i2", $urandom_range(0, 2));
            step("gap.p2", 8'h56, 1'b1, 1'b1, 8'h56, 1'b0, 1'b1);
            idle("gap.i3", $urandom_range(0, 2));
        end

        // 5: miss handling
        frm("miss1", 8'h00, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
        frm("good", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
        frm("missA", 8'h00, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
        frm("missB", 8'h00, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        frm("rl1", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        frm("rl2", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);

        // 6: VERIFY failure on a different rotation, not re-searched
        do_reset("r6");
        frm("vf1", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        frm("vf2", 8'h4B, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        frm("vf3", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        frm("vf4", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);
        check("vf.amt", 32'(rot_amt), 32'd0);

        // 6: asynchronous reset mid-payload
        step("mr.s", 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        step("mr.p0", 8'h12, 1'b1, 1'b1, 8'h12, 1'b1, 1'b1);
        in_data  = 8'h34;
        rst_n    = 1'b0;
        #2;
        check("mr.od", 32'(out_data), 32'd0);
        check("mr.ov", 32'(out_valid), 32'd0);
        check("mr.sof", 32'(out_sof), 32'd0);
        check("mr.lk", 32'(locked), 32'd0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step("mr.p2", 8'h56, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        frm("mrf1", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        frm("mrf2", 8'hA5, 8'h12, 8'h34, 8'h56, 1'b1, 1'b1, 8'h12, 8'h34, 8'h56);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
